// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and sizing helper for the sequential
// binary-to-BCD converter.
package bcd_pkg;

  localparam int BCD_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Decimal digits needed to show the largest unsigned value of 'width' bits.
  function automatic int digits_needed(input int width);
    longint max_v;
    int     d;
    max_v = (64'(1) << width) - 64'(1);
    d     = 1;
    for (int i = 0; i < 20; i++) begin
      if (max_v >= 64'd10) begin
        max_v = max_v / 64'd10;
        d     = d + 1;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/seq_bin_to_bcd_if.sv
// Start/ready request side and registered result side of the converter.
interface seq_bin_to_bcd_if #(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 6
) ();

  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  ready;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  overflow;
  logic [DIGITS-1:0]     blank;

  modport master (
    output start, bin_in,
    input  ready, done, bcd_out, overflow, blank
  );

  modport slave (
    input  start, bin_in,
    output ready, done, bcd_out, overflow, blank
  );

endinterface

// File: rtl/seq_bin_to_bcd_digit_cell.sv
// One double-dabble stage: add-3 correction on a BCD digit, then shift in
// the carry from the digit below; the corrected MSB carries upward.
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] digit_i,
  input  logic             carry_i,
  output logic [BCD_W-1:0] digit_o,
  output logic             carry_o
);

  logic [BCD_W-1:0] adj;

  assign adj     = (digit_i >= BCD_W'(5)) ? digit_i + BCD_W'(3) : digit_i;
  assign digit_o = {adj[BCD_W-2:0], carry_i};
  assign carry_o = adj[BCD_W-1];

endmodule

// File: rtl/seq_bin_to_bcd.sv
// Multi-cycle binary-to-BCD converter, one input bit per clock, with
// overflow detection and leading-zero blanking flags.
//
//   state | meaning
//   IDLE  | ready=1, waiting for start; results held
//   SHIFT | one add-3/shift step per edge, cnt_q edges remaining
module seq_bin_to_bcd
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 6
) (
  input logic              clk,
  input logic              reset,
  seq_bin_to_bcd_if.slave  bus
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int SCR_W = BCD_W * DIGITS;
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIN_W-1:0]     shift_q, shift_d;
  logic [SCR_W-1:0]     scratch_q, scratch_d;
  logic                 acc_q, acc_d;
  logic [SCR_W-1:0]     bcd_q, bcd_d;
  logic                 ovf_q, ovf_d;
  logic [DIGITS-1:0]    blank_q, blank_d;
  logic                 done_q, done_d;

  logic [DIGITS:0]      carry;
  logic [SCR_W-1:0]     scratch_shift;
  logic [DIGITS-1:0]    blank_calc;
  logic                 higher_zero;
  logic                 ovf_final;

  // Digit chain is fed from the shift-register MSB; carry[DIGITS] falls off the top.
  assign carry[0] = shift_q[BIN_W-1];

  for (genvar k = 0; k < DIGITS; k++) begin : g_cell
    bcd_digit_cell u_cell (
      .digit_i (scratch_q[BCD_W*k +: BCD_W]),
      .carry_i (carry[k]),
      .digit_o (scratch_shift[BCD_W*k +: BCD_W]),
      .carry_o (carry[k+1])
    );
  end

  assign ovf_final = acc_q | carry[DIGITS];

  always_comb begin
    blank_calc  = '0;
    higher_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      higher_zero   = higher_zero & (scratch_shift[BCD_W*k +: BCD_W] == '0);
      blank_calc[k] = higher_zero;
    end
    if (ovf_final) blank_calc = '0;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    acc_d     = acc_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    blank_d   = blank_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          shift_d   = bus.bin_in;
          scratch_d = '0;
          acc_d     = 1'b0;
          cnt_d     = CNT_W'(BIN_W);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        shift_d   = shift_q << 1;
        scratch_d = scratch_shift;
        acc_d     = ovf_final;
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = scratch_shift;
          ovf_d   = ovf_final;
          blank_d = blank_calc;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      scratch_q <= '0;
      acc_q     <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      blank_q   <= BLANK_RST;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      acc_q     <= acc_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      blank_q   <= blank_d;
      done_q    <= done_d;
    end
  end

  assign bus.ready    = (state_q == IDLE);
  assign bus.done     = done_q;
  assign bus.bcd_out  = bcd_q;
  assign bus.overflow = ovf_q;
  assign bus.blank    = blank_q;

endmodule

// File: tb/tb_seq_bin_to_bcd.sv
// Randomised and directed checks of seq_bin_to_bcd in a 20-bit/6-digit and an
// 8-bit/3-digit configuration against an arithmetic reference model.
module tb_seq_bin_to_bcd;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  seq_bin_to_bcd_if #(.BIN_W(20), .DIGITS(6)) if_a ();
  seq_bin_to_bcd_if #(.BIN_W(8),  .DIGITS(3)) if_b ();

  seq_bin_to_bcd #(.BIN_W(20), .DIGITS(6)) u_dut_a (
    .clk   (clk),
    .reset (rst_n),
    .bus   (if_a)
  );

  seq_bin_to_bcd #(.BIN_W(8), .DIGITS(3)) u_dut_b (
    .clk   (clk),
    .reset (rst_n),
    .bus   (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain decimal arithmetic on the input value.
  function automatic void ref_conv(input longint v, input int d, output logic [63:0] bcd,
                                   output logic ovf, output logic [7:0] blk);
    longint m;
    longint r;
    longint p;
    m = 1;
    for (int i = 0; i < d; i++) m = m * 10;
    ovf = (v >= m);
    r   = v % m;
    bcd = '0;
    blk = '0;
    p   = 1;
    for (int k = 0; k < d; k++) begin
      bcd = bcd | (64'((r / p) % 10) << (4 * k));
      if (k > 0 && !ovf && r < p) blk[k] = 1'b1;
      p = p * 10;
    end
  endfunction

  function automatic logic rdy(input int sel);
    return (sel == 0) ? if_a.ready : if_b.ready;
  endfunction

  function automatic logic dn(input int sel);
    return (sel == 0) ? if_a.done : if_b.done;
  endfunction

  function automatic logic [63:0] bcd_obs(input int sel);
    return (sel == 0) ? 64'(if_a.bcd_out) : 64'(if_b.bcd_out);
  endfunction

  function automatic logic ovf_obs(input int sel);
    return (sel == 0) ? if_a.overflow : if_b.overflow;
  endfunction

  function automatic logic [7:0] blank_obs(input int sel);
    return (sel == 0) ? 8'(if_a.blank) : 8'(if_b.blank);
  endfunction

  task automatic drive(input int sel, input logic s, input longint v);
    logic [63:0] vv;
    vv = 64'(v);
    if (sel == 0) begin
      if_a.start  = s;
      if_a.bin_in = vv[19:0];
    end else begin
      if_b.start  = s;
      if_b.bin_in = vv[7:0];
    end
  endtask

  task automatic check_result(input int sel, input longint v, input string tag);
    logic [63:0] eb;
    logic        eo;
    logic [7:0]  ebl;
    ref_conv(v, (sel == 0) ? 6 : 3, eb, eo, ebl);
    check({tag, " bcd"},      bcd_obs(sel),         eb);
    check({tag, " overflow"}, 64'(ovf_obs(sel)),    64'(eo));
    check({tag, " blank"},    64'(blank_obs(sel)),  64'(ebl));
  endtask

  task automatic run_conv(input int sel, input longint v, input string tag);
    int n;
    int lat;
    n = 0;
    while (!rdy(sel) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " ready"}, 64'(rdy(sel)), 64'd1);
    @(negedge clk);
    drive(sel, 1'b1, v);
    @(posedge clk); #1;
    check({tag, " ready drop"}, 64'(rdy(sel)), 64'd0);
    @(negedge clk);
    drive(sel, 1'b0, longint'($urandom));
    lat = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (dn(sel)) begin
        lat = i;
        break;
      end
    end
    check({tag, " latency"}, 64'(lat), (sel == 0) ? 64'd20 : 64'd8);
    check({tag, " ready at done"}, 64'(rdy(sel)), 64'd1);
    check_result(sel, v, tag);
    @(posedge clk); #1;
    check({tag, " done width"}, 64'(dn(sel)), 64'd0);
    check_result(sel, v, {tag, " hold"});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    int lat;
    int dones;
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    drive(0, 1'b0, 0);
    drive(1, 1'b0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    check("rst ready",    64'(if_a.ready),    64'd1);
    check("rst done",     64'(if_a.done),     64'd0);
    check("rst bcd",      64'(if_a.bcd_out),  64'd0);
    check("rst overflow", 64'(if_a.overflow), 64'd0);
    check("rst blank",    64'(if_a.blank),    64'b111110);
    check("rst blank b",  64'(if_b.blank),    64'b110);

    run_conv(0, 0,       "zero");
    run_conv(0, 999999,  "max6");
    run_conv(0, 1048575, "full20");
    run_conv(0, 1000000, "1e6");
    for (int i = 0; i < 20; i++) run_conv(0, longint'($urandom & 32'hFFFFF), "rand");
    for (int i = 0; i < 5; i++)  run_conv(0, longint'($urandom_range(0, 999)), "rand small");

    // Start held toggling while busy, then back-to-back start in the done cycle.
    @(negedge clk);
    drive(0, 1'b1, 305);
    @(posedge clk); #1;
    first = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if_a.start  = ~if_a.start;
      if_a.bin_in = 20'($urandom);
      @(posedge clk); #1;
      if (if_a.done) begin
        first = i;
        break;
      end
    end
    check("toggle latency", 64'(first), 64'd20);
    check_result(0, 305, "toggle");
    check("toggle blank const", 64'(if_a.blank), 64'b111000);
    @(negedge clk);
    drive(0, 1'b1, 42);
    @(posedge clk); #1;
    check("b2b accepted", 64'(if_a.ready), 64'd0);
    @(negedge clk);
    drive(0, 1'b0, longint'($urandom));
    lat = 0;
    for (int i = 2; i <= 60; i++) begin
      @(posedge clk); #1;
      if (if_a.done) begin
        lat = i;
        break;
      end
    end
    check("b2b spacing", 64'(lat), 64'd21);
    check_result(0, 42, "b2b");

    // Reset in the middle of a conversion.
    @(negedge clk);
    drive(0, 1'b1, 123456);
    @(posedge clk); #1;
    @(negedge clk);
    drive(0, 1'b0, 0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort ready",    64'(if_a.ready),    64'd1);
    check("abort done",     64'(if_a.done),     64'd0);
    check("abort bcd",      64'(if_a.bcd_out),  64'd0);
    check("abort overflow", 64'(if_a.overflow), 64'd0);
    check("abort blank",    64'(if_a.blank),    64'b111110);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (if_a.done) dones++;
    end
    check("abort no done", 64'(dones), 64'd0);
    run_conv(0, 7, "after reset");

    for (int v = 0; v < 256; v++) run_conv(1, longint'(v), "sweep8");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
